mips8_multicycle_ctrl: RTL and testbench

Control unit for the 8-bit multicycle MIPS datapath (datav). Sequences byte-wide instruction fetch into the 32-bit IR, then decode, execute, memory and writeback for lb, sb, R-type, beq, j and addi. It drives every datapath select/enable directly from a Moore FSM plus an ALU decoder. The only Mealy term is the branch qualification of pcen.

---
 rtl/mips8_multicycle_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mips8_multicycle_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mips8_multicycle_ctrl.sv
// Moore control FSM plus ALU decoder for the 8-bit multicycle MIPS datapath.
// Byte-wide fetch into the IR; pcen is the only Mealy output (qualified by zero in BEQEX).
module mips8_multicycle_ctrl #(
  parameter logic [5:0] OP_LB    = 6'h20,
  parameter logic [5:0] OP_SB    = 6'h28,
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       memtoreg,
  output logic       regdst,
  output logic       iord,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       regwrite,
  output logic [3:0] irwrite,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14,
    ILLEGAL = 4'd15
  } state_t;

  state_t state_q, state_d;

  logic       memread_s, memwrite_s, alusrca_s, memtoreg_s, regdst_s, iord_s, pcen_s, regwrite_s;
  logic [1:0] alusrcb_s, pcsrc_s;
  logic [2:0] alucontrol_s;
  logic [3:0] irwrite_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH1;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH1;
    unique case (state_q)
      FETCH1: state_d = FETCH2;
      FETCH2: state_d = FETCH3;
      FETCH3: state_d = FETCH4;
      FETCH4: state_d = DECODE;
      DECODE: begin
        if (op == OP_LB || op == OP_SB) state_d = MEMADR;
        else if (op == OP_RTYPE)        state_d = RTYPEEX;
        else if (op == OP_BEQ)          state_d = BEQEX;
        else if (op == OP_J)            state_d = JEX;
        else if (op == OP_ADDI)         state_d = ADDIEX;
        else                            state_d = FETCH1;
      end
      MEMADR:  state_d = (op == OP_LB) ? LBRD : SBWR;
      LBRD:    state_d = LBWR;
      RTYPEEX: state_d = RTYPEWR;
      ADDIEX:  state_d = ADDIWR;
      default: state_d = FETCH1;
    endcase
  end

  always_comb begin
    memread_s    = 1'b0;
    memwrite_s   = 1'b0;
    alusrca_s    = 1'b0;
    alusrcb_s    = 2'b00;
    alucontrol_s = 3'b010;
    memtoreg_s   = 1'b0;
    regdst_s     = 1'b0;
    iord_s       = 1'b0;
    pcen_s       = 1'b0;
    pcsrc_s      = 2'b00;
    regwrite_s   = 1'b0;
    irwrite_s    = 4'b0000;
    unique case (state_q)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        memread_s = 1'b1;
        alusrcb_s = 2'b01;
        pcen_s    = 1'b1;
        irwrite_s = 4'b0001 << state_q[1:0];
      end
      // Branch target is formed here so BEQEX only needs the compare.
      DECODE: alusrcb_s = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      LBRD: begin
        memread_s = 1'b1;
        iord_s    = 1'b1;
      end
      LBWR: begin
        regwrite_s = 1'b1;
        memtoreg_s = 1'b1;
      end
      SBWR: begin
        memwrite_s = 1'b1;
        iord_s     = 1'b1;
      end
      RTYPEEX: begin
        alusrca_s = 1'b1;
        case (funct)
          6'b100010: alucontrol_s = 3'b110;
          6'b100100: alucontrol_s = 3'b000;
          6'b100101: alucontrol_s = 3'b001;
          6'b101010: alucontrol_s = 3'b111;
          default:   alucontrol_s = 3'b010;
        endcase
      end
      RTYPEWR: begin
        regwrite_s = 1'b1;
        regdst_s   = 1'b1;
      end
      BEQEX: begin
        alusrca_s    = 1'b1;
        alucontrol_s = 3'b110;
        pcsrc_s      = 2'b01;
        pcen_s       = zero;
      end
      JEX: begin
        pcen_s  = 1'b1;
        pcsrc_s = 2'b10;
      end
      ADDIWR: regwrite_s = 1'b1;
      ILLEGAL: alucontrol_s = 3'b000;
      default: ;
    endcase
  end

  // Reset masks every output combinationally so an abort takes effect at once.
  assign memread    = reset & memread_s;
  assign memwrite   = reset & memwrite_s;
  assign alusrca    = reset & alusrca_s;
  assign alusrcb    = reset ? alusrcb_s : 2'b00;
  assign alucontrol = reset ? alucontrol_s : 3'b000;
  assign memtoreg   = reset & memtoreg_s;
  assign regdst     = reset & regdst_s;
  assign iord       = reset & iord_s;
  assign pcen       = reset & pcen_s;
  assign pcsrc      = reset ? pcsrc_s : 2'b00;
  assign regwrite   = reset & regwrite_s;
  assign irwrite    = reset ? irwrite_s : 4'b0000;
  assign state      = reset ? state_q : 4'b0000;

endmodule

// File: tb/tb_mips8_multicycle_ctrl.sv
// Bench for mips8_multicycle_ctrl: per-instruction cycle model, vector table, random ops, reset corners.
module tb_mips8_multicycle_ctrl;

  localparam logic [5:0] OP_LB = 6'h20, OP_SB = 6'h28, OP_RTYPE = 6'h00,
                         OP_BEQ = 6'h04, OP_J = 6'h02, OP_ADDI = 6'h08;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'h00, funct = 6'h00;
  logic       zero = 1'b0;
  logic       memread, memwrite, alusrca, memtoreg, regdst, iord, pcen, regwrite;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] irwrite, state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       memread, memwrite, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       memtoreg, regdst, iord, pcen;
    logic [1:0] pcsrc;
    logic       regwrite;
    logic [3:0] irwrite;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         lat;
  } vec_t;

  mips8_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .alucontrol(alucontrol), .memtoreg(memtoreg), .regdst(regdst), .iord(iord),
    .pcen(pcen), .pcsrc(pcsrc), .regwrite(regwrite), .irwrite(irwrite), .state(state)
  );

  always #5 clk = ~clk;

  function automatic outs_t sample();
    outs_t s;
    s = '{memread, memwrite, alusrca, alusrcb, alucontrol, memtoreg, regdst, iord,
          pcen, pcsrc, regwrite, irwrite, state};
    return s;
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic int lat_of(input logic [5:0] o);
    if (o == OP_LB) return 8;
    if (o == OP_SB || o == OP_RTYPE || o == OP_ADDI) return 7;
    if (o == OP_BEQ || o == OP_J) return 6;
    return 5;
  endfunction

  // Expected outputs for cycle k (0 = first fetch cycle) of an instruction.
  function automatic outs_t model(input logic [5:0] o, input logic [5:0] f, input logic z, input int k);
    outs_t e;
    e = '0;
    e.alucontrol = 3'b010;
    if (k < 4) begin
      e.memread = 1'b1; e.alusrcb = 2'b01; e.pcen = 1'b1;
      e.irwrite = 4'(1 << k); e.state = 4'(k);
    end else if (k == 4) begin
      e.alusrcb = 2'b11; e.state = 4'd4;
    end else if (o == OP_LB || o == OP_SB) begin
      if (k == 5) begin e.state = 4'd5; e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      else if (o == OP_LB && k == 6) begin e.state = 4'd6; e.memread = 1'b1; e.iord = 1'b1; end
      else if (o == OP_LB) begin e.state = 4'd7; e.regwrite = 1'b1; e.memtoreg = 1'b1; end
      else begin e.state = 4'd8; e.memwrite = 1'b1; e.iord = 1'b1; end
    end else if (o == OP_RTYPE) begin
      if (k == 5) begin e.state = 4'd9; e.alusrca = 1'b1; e.alucontrol = alu_of(f); end
      else begin e.state = 4'd10; e.regwrite = 1'b1; e.regdst = 1'b1; end
    end else if (o == OP_BEQ) begin
      e.state = 4'd11; e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcen = z;
    end else if (o == OP_J) begin
      e.state = 4'd12; e.pcen = 1'b1; e.pcsrc = 2'b10;
    end else if (o == OP_ADDI) begin
      if (k == 5) begin e.state = 4'd13; e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      else begin e.state = 4'd14; e.regwrite = 1'b1; end
    end
    return e;
  endfunction

  task automatic check(input string name, input int k, input outs_t got, input outs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %p required %p", name, k, got, exp);
    end
  endtask

  task automatic check_excl(input string name, input int k);
    int nw;
    nw = int'(irwrite != 4'b0) + int'(memwrite) + int'(regwrite);
    n_checks++;
    if (nw > 1 || (memread && memwrite)) begin
      n_fail++;
      $display("FAIL %s exclusivity cycle %0d: irwrite=%b memwrite=%b regwrite=%b memread=%b",
               name, k, irwrite, memwrite, regwrite, memread);
    end
  endtask

  // Called #1 after an edge with the DUT in FETCH1; leaves it ncyc edges later.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int ncyc, input string name);
    op = o; funct = f; zero = z;
    for (int k = 0; k < ncyc; k++) begin
      #1;
      check(name, k, sample(), model(o, f, z, k));
      check_excl(name, k);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_zero(input string name, input int k);
    check(name, k, sample(), outs_t'('0));
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{OP_ADDI,  6'h00, 1'b0, 7};
    vecs[1]  = '{OP_RTYPE, 6'h2A, 1'b0, 7};
    vecs[2]  = '{OP_RTYPE, 6'h20, 1'b0, 7};
    vecs[3]  = '{OP_RTYPE, 6'h22, 1'b1, 7};
    vecs[4]  = '{OP_RTYPE, 6'h24, 1'b0, 7};
    vecs[5]  = '{OP_RTYPE, 6'h25, 1'b0, 7};
    vecs[6]  = '{OP_BEQ,   6'h00, 1'b1, 6};
    vecs[7]  = '{OP_BEQ,   6'h00, 1'b0, 6};
    vecs[8]  = '{OP_LB,    6'h00, 1'b0, 8};
    vecs[9]  = '{OP_SB,    6'h00, 1'b0, 7};
    vecs[10] = '{OP_J,     6'h00, 1'b0, 6};
    vecs[11] = '{6'h3F,    6'h00, 1'b0, 5};

    // Reset held for three cycles: everything reads zero.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_zero("reset_hold", k);
    end
    @(posedge clk); #1;
    reset = 1'b1;

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].lat, $sformatf("vec%0d", i));
      n_checks++;
      if (state !== 4'd0) begin
        n_fail++;
        $display("FAIL vec%0d_return: state %0d required 0 after %0d cycles", i, state, vecs[i].lat);
      end
    end

    // Random instruction stream, including unknown opcodes and arbitrary funct codes.
    for (int i = 0; i < 40; i++) begin
      logic [5:0] o, f;
      case ($urandom_range(0, 7))
        0: o = OP_LB;
        1: o = OP_SB;
        2: o = OP_RTYPE;
        3: o = OP_BEQ;
        4: o = OP_J;
        5: o = OP_ADDI;
        default: o = 6'($urandom_range(0, 63));
      endcase
      f = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63))
                                      : (6'h20 | 6'($urandom_range(0, 10)));
      run_instr(o, f, 1'($urandom_range(0, 1)), lat_of(o), $sformatf("rand%0d", i));
    end

    // Abort during RTYPEWR: outputs drop at once, restart at FETCH1.
    run_instr(OP_RTYPE, 6'h22, 1'b0, 6, "abort_pre");
    #1;
    check("abort_in_rtypewr", 6, sample(), model(OP_RTYPE, 6'h22, 1'b0, 6));
    reset = 1'b0;
    #1;
    check_zero("abort_immediate", 0);
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      check_zero("abort_hold", k);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    run_instr(OP_ADDI, 6'h00, 1'b0, 7, "after_abort");
    run_instr(OP_BEQ, 6'h00, 1'b1, 6, "after_abort_beq");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t required under 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
